// File: rtl/calc_control_unit_ext.sv
// Keypad-driven calculator controller: decimal operand entry, + - x / with
// left-to-right chaining, WIDTH-cycle restoring divider and a sticky ERROR state.
module calc_control_unit_ext #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       button,
    input  logic             is_pressed_next,
    output logic [WIDTH-1:0] operand_f,
    output logic [WIDTH-1:0] operand_s,
    output logic [WIDTH-1:0] display_value,
    output logic [2:0]       state,
    output logic             busy,
    output logic             error
);

    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int DIV_W  = $clog2(WIDTH);
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_INITIAL   = 3'd0,
        S_OPERAND_F = 3'd1,
        S_OPERATION = 3'd2,
        S_OPERAND_S = 3'd3,
        S_COMPUTE   = 3'd4,
        S_RESULT    = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_t;

    state_t               r_state,     w_state;
    state_t               r_pending,   w_pending;
    alu_op_t              r_alu_op,    w_alu_op;
    alu_op_t              r_queued_op, w_queued_op;
    logic [WIDTH-1:0]     r_operand_f, w_operand_f;
    logic [WIDTH-1:0]     r_operand_s, w_operand_s;
    logic [CNT_W-1:0]     r_cnt_f,     w_cnt_f;
    logic [CNT_W-1:0]     r_cnt_s,     w_cnt_s;
    logic [WIDTH-1:0]     r_div_q,     w_div_q;
    logic [WIDTH-1:0]     r_div_r,     w_div_r;
    logic [DIV_W-1:0]     r_div_cnt,   w_div_cnt;
    logic                 r_pressed_q;

    logic                 w_press;
    logic                 w_is_digit;
    logic                 w_is_op;
    logic                 w_is_equal;
    logic                 w_is_clear;
    alu_op_t              w_key_op;
    logic [WIDTH-1:0]     w_digit;

    logic [WIDTH:0]       w_sum;
    logic [PROD_W-1:0]    w_prod;
    logic [WIDTH:0]       w_rem_shift;
    logic                 w_rem_ge;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;
    logic                 w_alu_done;
    logic                 w_alu_fail;
    logic [WIDTH-1:0]     w_alu_result;

    // Key decode: only the rising edge of the debounced level is an event.
    assign w_press    = is_pressed_next & ~r_pressed_q;
    assign w_is_digit = (button <= 4'd9);
    assign w_is_op    = (button >= 4'hA) && (button <= 4'hD);
    assign w_is_equal = (button == 4'hE);
    assign w_is_clear = (button == 4'hF);
    assign w_digit    = WIDTH'(button);

    always_comb begin
        case (button)
            4'hA:    w_key_op = OP_ADD;
            4'hB:    w_key_op = OP_SUB;
            4'hC:    w_key_op = OP_MUL;
            default: w_key_op = OP_DIV;
        endcase
    end

    assign w_sum  = {1'b0, r_operand_f} + {1'b0, r_operand_s};
    assign w_prod = PROD_W'(r_operand_f) * PROD_W'(r_operand_s);

    // One restoring step per cycle; the dividend shifts out of r_div_q MSB first
    // while quotient bits shift in at the bottom.
    assign w_rem_shift = {r_div_r, r_div_q[WIDTH-1]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_operand_s});
    assign w_rem_next  = w_rem_ge ? (w_rem_shift[WIDTH-1:0] - r_operand_s)
                                  : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_div_q[WIDTH-2:0], w_rem_ge};

    always_comb begin
        w_alu_done   = 1'b1;
        w_alu_fail   = 1'b0;
        w_alu_result = w_sum[WIDTH-1:0];
        case (r_alu_op)
            OP_ADD: begin
                w_alu_fail   = w_sum[WIDTH];
                w_alu_result = w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                w_alu_fail   = (r_operand_f < r_operand_s);
                w_alu_result = r_operand_f - r_operand_s;
            end
            OP_MUL: begin
                w_alu_fail   = |w_prod[PROD_W-1:WIDTH];
                w_alu_result = w_prod[WIDTH-1:0];
            end
            OP_DIV: begin
                w_alu_fail   = (r_operand_s == '0);
                w_alu_done   = w_alu_fail || (r_div_cnt == DIV_W'(WIDTH - 1));
                w_alu_result = w_quo_next;
            end
        endcase
    end

    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    always_comb begin
        w_state     = r_state;
        w_pending   = r_pending;
        w_alu_op    = r_alu_op;
        w_queued_op = r_queued_op;
        w_operand_f = r_operand_f;
        w_operand_s = r_operand_s;
        w_cnt_f     = r_cnt_f;
        w_cnt_s     = r_cnt_s;
        w_div_q     = r_div_q;
        w_div_r     = r_div_r;
        w_div_cnt   = r_div_cnt;

        if (w_press && w_is_clear) begin
            w_state     = S_INITIAL;
            w_pending   = S_RESULT;
            w_alu_op    = OP_ADD;
            w_queued_op = OP_ADD;
            w_operand_f = '0;
            w_operand_s = '0;
            w_cnt_f     = '0;
            w_cnt_s     = '0;
            w_div_q     = '0;
            w_div_r     = '0;
            w_div_cnt   = '0;
        end else begin
            case (r_state)
                S_INITIAL, S_RESULT: begin
                    if (w_press && w_is_digit) begin
                        w_operand_f = w_digit;
                        w_cnt_f     = CNT_W'(1);
                        w_state     = S_OPERAND_F;
                    end else if (w_press && w_is_op && r_state == S_RESULT) begin
                        w_alu_op = w_key_op;
                        w_state  = S_OPERATION;
                    end
                end
                S_OPERAND_F: begin
                    if (w_press && w_is_digit && r_cnt_f < CNT_W'(MAX_DIGITS)) begin
                        w_operand_f = r_operand_f * WIDTH'(10) + w_digit;
                        w_cnt_f     = r_cnt_f + CNT_W'(1);
                    end else if (w_press && w_is_op) begin
                        w_alu_op = w_key_op;
                        w_state  = S_OPERATION;
                    end
                end
                S_OPERATION: begin
                    if (w_press && w_is_op) begin
                        w_alu_op = w_key_op;
                    end else if (w_press && w_is_digit) begin
                        w_operand_s = w_digit;
                        w_cnt_s     = CNT_W'(1);
                        w_state     = S_OPERAND_S;
                    end
                end
                S_OPERAND_S: begin
                    if (w_press && w_is_digit && r_cnt_s < CNT_W'(MAX_DIGITS)) begin
                        w_operand_s = r_operand_s * WIDTH'(10) + w_digit;
                        w_cnt_s     = r_cnt_s + CNT_W'(1);
                    end else if (w_press && (w_is_equal || w_is_op)) begin
                        w_pending   = w_is_equal ? S_RESULT : S_OPERATION;
                        w_queued_op = w_is_op ? w_key_op : r_queued_op;
                        w_div_q     = r_operand_f;
                        w_div_r     = '0;
                        w_div_cnt   = '0;
                        w_state     = S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (w_alu_fail) begin
                        w_state = S_ERROR;
                    end else begin
                        w_div_q   = w_quo_next;
                        w_div_r   = w_rem_next;
                        w_div_cnt = r_div_cnt + DIV_W'(1);
                        if (w_alu_done) begin
                            w_operand_f = w_alu_result;
                            w_operand_s = '0;
                            w_state     = r_pending;
                            if (r_pending == S_OPERATION) begin
                                w_alu_op = r_queued_op;
                            end
                        end
                    end
                end
                default: begin
                    // ERROR is sticky until CLEAR or reset
                end
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before this edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_INITIAL;
            r_pending   <= S_RESULT;
            r_alu_op    <= OP_ADD;
            r_queued_op <= OP_ADD;
            r_operand_f <= '0;
            r_operand_s <= '0;
            r_cnt_f     <= '0;
            r_cnt_s     <= '0;
            r_div_q     <= '0;
            r_div_r     <= '0;
            r_div_cnt   <= '0;
            r_pressed_q <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pending   <= w_pending;
            r_alu_op    <= w_alu_op;
            r_queued_op <= w_queued_op;
            r_operand_f <= w_operand_f;
            r_operand_s <= w_operand_s;
            r_cnt_f     <= w_cnt_f;
            r_cnt_s     <= w_cnt_s;
            r_div_q     <= w_div_q;
            r_div_r     <= w_div_r;
            r_div_cnt   <= w_div_cnt;
            r_pressed_q <= is_pressed_next;
        end
    end

    assign operand_f     = r_operand_f;
    assign operand_s     = r_operand_s;
    assign display_value = (r_state == S_OPERAND_S) ? r_operand_s : r_operand_f;
    assign state         = r_state;
    assign busy          = (r_state == S_COMPUTE);
    assign error         = (r_state == S_ERROR);

endmodule

// File: doc/calc_control_unit_ext.md
Name: calc_control_unit_ext

Overview:
Parametrised successor to the calculator control unit. Accepts debounced keypad codes, builds two WIDTH-bit unsigned operands in decimal, and evaluates + − × ÷. Adds left-to-right operator chaining, a multi-cycle restoring divider, digit-count limiting, and an ERROR state for overflow, underflow and divide-by-zero. Sits between the keypad debouncer and the OLED display driver.

Parameters:
WIDTH, 32, operand/result width in bits (unsigned); must be ≥ 8.
MAX_DIGITS, 9, maximum decimal digits accepted per operand; must satisfy 10^MAX_DIGITS − 1 < 2^WIDTH.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
button  input  4  key code: 0x0–0x9 digits, 0xA ADD, 0xB SUB, 0xC MUL, 0xD DIV, 0xE EQUAL, 0xF CLEAR
is_pressed_next  input  1  debounced key-down level
operand_f  output  WIDTH  first operand / accumulator / result
operand_s  output  WIDTH  second operand
display_value  output  WIDTH  operand_s in OPERAND_S, else operand_f
state  output  3  current FSM state encoding
busy  output  1  high while in COMPUTE
error  output  1  high while in ERROR

Behaviour:
- Reset (reset=0, async): state=INITIAL, operand_f=0, operand_s=0, alu_op=ADD, digit counters=0, pressed_q=0, busy=0, error=0.
- Press event: press = is_pressed_next & ~pressed_q, where pressed_q is registered every cycle. button is sampled only in the press cycle. Holding a key produces exactly one event.
- State encodings: INITIAL=0, OPERAND_F=1, OPERATION=2, OPERAND_S=3, COMPUTE=4, RESULT=5, ERROR=6.
- CLEAR from any state, including COMPUTE and ERROR: next cycle state=INITIAL and all registers return to their reset values. Any in-progress divide is aborted.
- INITIAL:
  - digit d → operand_f=d, count=1, go to OPERAND_F.
  - op/EQUAL → ignored.
- OPERAND_F:
  - digit → operand_f=operand_f*10+d only if count<MAX_DIGITS; otherwise the digit is ignored.
  - op → latch alu_op, go to OPERATION.
  - EQUAL → ignored.
- OPERATION:
  - op → replace alu_op.
  - digit → operand_s=d, count=1, go to OPERAND_S.
  - EQUAL → ignored.
- OPERAND_S:
  - digit → accumulate, same limit rule as OPERAND_F.
  - EQUAL → go to COMPUTE with pending_next=RESULT.
  - op → latch new op as queued_op, go to COMPUTE with pending_next=OPERATION (chaining).
- COMPUTE:
  - busy=1; all non-CLEAR presses are discarded.
  - ADD/SUB/MUL take 1 cycle.
  - DIV takes exactly WIDTH cycles (restoring, one quotient bit per cycle, MSB first). Divide-by-zero is detected in the first cycle → ERROR after that cycle.
  - On completion: operand_f=result, operand_s=0, then go to pending_next. On chaining, alu_op=queued_op.
- Error conditions: ADD carry out of WIDTH bits, SUB with operand_f<operand_s, MUL product ≥ 2^WIDTH, DIV by 0. On error: go to ERROR, operand_f unchanged, error=1.
- RESULT:
  - digit → start new operand_f, go to OPERAND_F.
  - op → alu_op=op, go to OPERATION using result as first operand.
  - EQUAL → ignored.
- ERROR: only CLEAR (or reset) exits; all other keys are ignored.
- Latency: press edge sampled at cycle N → state change visible at N+1. ADD/SUB/MUL result visible at N+2. DIV result visible at N+1+WIDTH.
- DIV truncates toward zero; the remainder is discarded.

Test Plan:
- WIDTH=16, MAX_DIGITS=4. Keys 1,2,+,3,4,= → operand_f=46 two cycles after EQUAL edge, state=RESULT, operand_s=0.
- 1,0,0,÷,7,= → busy=1 for exactly 16 cycles, then operand_f=14 and state=RESULT. Keys pressed during busy leave all state unchanged.
- 2,+,3,×,4,= → after ×, state=OPERATION with operand_f=5; final operand_f=20. Then 5 pressed → state=OPERAND_F, operand_f=5.
- Keys 1,2,3,4,5 → operand_f=1234. A single key held high for 10 cycles enters exactly one digit.
- Error paths: 3,−,5,= → error=1, state=6. 5,÷,0,= → ERROR after 1 COMPUTE cycle. 9,9,9,9,×,9,9,9,9,= → ERROR. In each case digits and operators are ignored until CLEAR, after which state=INITIAL and both operands=0.
- reset pulsed low mid-divide (cycle 5 of 16) → outputs at reset values immediately. Operation resumes normally after release.
